// File: rtl/ifu_sram_rsp.sv
// AXI-lite read responder for the IFU fetch port, backed by a 64-bit instruction SRAM model.
// In-order responses after a fixed latency, with a byte-strobed backdoor write port.
module ifu_sram_rsp #(
  parameter logic [63:0] ADDR_BASE  = 64'h8000_0000,
  parameter int          DEPTH_LOG2 = 12,
  parameter int          LATENCY    = 2,
  parameter int          OSTD       = 4,
  parameter string       INIT_FILE  = ""
) (
  input  logic        clk,
  input  logic        syn_rst,
  input  logic        ifu_arvalid,
  output logic        ifu_arready,
  input  logic [63:0] ifu_araddr,
  output logic        ifu_rvalid,
  input  logic        ifu_rready,
  output logic [1:0]  ifu_rresp,
  output logic [63:0] ifu_rdata,
  input  logic        mem_wen,
  input  logic [63:0] mem_waddr,
  input  logic [63:0] mem_wdata,
  input  logic [7:0]  mem_wstrb
);

  localparam int          DEPTH     = 1 << DEPTH_LOG2;
  localparam logic [63:0] MEM_BYTES = 64'(DEPTH) << 3;
  localparam int          OW        = $clog2(OSTD + 1);
  localparam int          PW        = (OSTD > 1) ? $clog2(OSTD) : 1;
  localparam logic [2:0]  CNT_INIT  = 3'((LATENCY >= 2) ? LATENCY - 2 : 0);
  localparam logic [OW-1:0] OSTD_W  = OW'(OSTD);
  localparam logic [PW-1:0] LAST_PTR = PW'(OSTD - 1);

  typedef enum logic [1:0] {
    RESP_OKAY   = 2'b00,
    RESP_SLVERR = 2'b10,
    RESP_DECERR = 2'b11
  } resp_e;

  logic [63:0]           mem [DEPTH];

  resp_e                 q_resp [OSTD];
  logic [DEPTH_LOG2-1:0] q_idx  [OSTD];
  logic [2:0]            q_cnt  [OSTD];
  logic [PW-1:0]         wr_ptr, rd_ptr;
  logic [OW-1:0]         q_count, occupancy;

  logic [63:0]           ar_off, w_off;
  logic                  ar_in_range, w_in_range;
  resp_e                 ar_resp;
  logic [DEPTH_LOG2-1:0] ar_idx, w_idx;

  logic                  ar_hs, r_hs, out_free, head_ok, bypass, load, push, pop;
  resp_e                 ld_resp;
  logic [DEPTH_LOG2-1:0] ld_idx;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == LAST_PTR) ? '0 : p + PW'(1);
  endfunction

  assign ar_off      = ifu_araddr - ADDR_BASE;
  assign ar_in_range = (ifu_araddr >= ADDR_BASE) && (ar_off < MEM_BYTES);
  assign ar_idx      = ar_off[DEPTH_LOG2+2:3];
  assign w_off       = mem_waddr - ADDR_BASE;
  assign w_in_range  = (mem_waddr >= ADDR_BASE) && (w_off < MEM_BYTES);
  assign w_idx       = w_off[DEPTH_LOG2+2:3];

  assign ifu_arready = (occupancy < OSTD_W);

  // Out-of-range takes priority over misalignment.
  always_comb begin
    ar_resp = RESP_OKAY;
    if (!ar_in_range) begin
      ar_resp = RESP_DECERR;
    end else if (ifu_araddr[2:0] != 3'b000) begin
      ar_resp = RESP_SLVERR;
    end
  end

  // With LATENCY==1 a request arriving to an empty queue goes straight to the output register.
  always_comb begin
    ar_hs    = ifu_arvalid && ifu_arready;
    r_hs     = ifu_rvalid && ifu_rready;
    out_free = !ifu_rvalid || ifu_rready;
    head_ok  = (q_count != '0) && (q_cnt[rd_ptr] == 3'd0);
    bypass   = (LATENCY == 1) && (q_count == '0) && ar_hs && out_free;
    load     = out_free && (head_ok || bypass);
    push     = ar_hs && !bypass;
    pop      = load && !bypass;
    ld_resp  = bypass ? ar_resp : q_resp[rd_ptr];
    ld_idx   = bypass ? ar_idx : q_idx[rd_ptr];
  end

  always_ff @(posedge clk) begin
    if (syn_rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      q_count   <= '0;
      occupancy <= '0;
      for (int i = 0; i < OSTD; i++) begin
        q_cnt[i]  <= '0;
        q_resp[i] <= RESP_OKAY;
        q_idx[i]  <= '0;
      end
    end else begin
      for (int i = 0; i < OSTD; i++) begin
        if (q_cnt[i] != 3'd0) q_cnt[i] <= q_cnt[i] - 3'd1;
      end
      if (push) begin
        q_resp[wr_ptr] <= ar_resp;
        q_idx[wr_ptr]  <= ar_idx;
        q_cnt[wr_ptr]  <= CNT_INIT;
        wr_ptr         <= next_ptr(wr_ptr);
      end
      if (pop) rd_ptr <= next_ptr(rd_ptr);
      q_count   <= q_count + OW'(push) - OW'(pop);
      occupancy <= occupancy + OW'(ar_hs) - OW'(r_hs);
    end
  end

  always_ff @(posedge clk) begin
    if (syn_rst) begin
      ifu_rvalid <= 1'b0;
      ifu_rresp  <= 2'b00;
      ifu_rdata  <= '0;
    end else if (load) begin
      ifu_rvalid <= 1'b1;
      ifu_rresp  <= ld_resp;
      ifu_rdata  <= (ld_resp == RESP_OKAY) ? mem[ld_idx] : '0;
    end else if (r_hs) begin
      ifu_rvalid <= 1'b0;
    end
  end

  // A write to the word being loaded lands at the same edge, so the read sees the old data.
  always_ff @(posedge clk) begin
    if (mem_wen && w_in_range) begin
      for (int b = 0; b < 8; b++) begin
        if (mem_wstrb[b]) mem[w_idx][8*b +: 8] <= mem_wdata[8*b +: 8];
      end
    end
  end

endmodule

// File: tb/tb_ifu_sram_rsp.sv
// Scoreboard bench for ifu_sram_rsp: stimulus pushes expected responses, a negedge monitor pops
// and compares them on every r handshake.
module tb_ifu_sram_rsp;

  localparam logic [63:0] BASE  = 64'h8000_0000;
  localparam logic [63:0] W0    = 64'h0000_0013_0000_0013;
  localparam logic [63:0] W1    = 64'h1111_1111_1111_1111;
  localparam logic [63:0] W2    = 64'h2222_3333_4444_5555;
  localparam logic [63:0] W3    = 64'h0123_4567_89AB_CDEF;
  localparam logic [63:0] WLAST = 64'hDEAD_BEEF_CAFE_F00D;

  logic        clk;
  logic        syn_rst;
  logic        ifu_arvalid;
  logic        ifu_arready;
  logic [63:0] ifu_araddr;
  logic        ifu_rvalid;
  logic        ifu_rready;
  logic [1:0]  ifu_rresp;
  logic [63:0] ifu_rdata;
  logic        mem_wen;
  logic [63:0] mem_waddr;
  logic [63:0] mem_wdata;
  logic [7:0]  mem_wstrb;

  typedef struct packed {
    logic [1:0]  resp;
    logic [63:0] data;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_compared   = 0;
  int   n_mismatched = 0;

  ifu_sram_rsp dut (
    .clk         (clk),
    .syn_rst     (syn_rst),
    .ifu_arvalid (ifu_arvalid),
    .ifu_arready (ifu_arready),
    .ifu_araddr  (ifu_araddr),
    .ifu_rvalid  (ifu_rvalid),
    .ifu_rready  (ifu_rready),
    .ifu_rresp   (ifu_rresp),
    .ifu_rdata   (ifu_rdata),
    .mem_wen     (mem_wen),
    .mem_waddr   (mem_waddr),
    .mem_wdata   (mem_wdata),
    .mem_wstrb   (mem_wstrb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_compared++;
    if (act !== exp) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic backdoor_write(input logic [63:0] addr, input logic [63:0] data, input logic [7:0] strb);
    mem_wen   = 1'b1;
    mem_waddr = addr;
    mem_wdata = data;
    mem_wstrb = strb;
    tick();
    mem_wen   = 1'b0;
  endtask

  // Holds arvalid until accepted; leaves arvalid low so back-to-back calls stay gapless.
  task automatic send_ar(input logic [63:0] addr, input logic [1:0] resp, input logic [63:0] data);
    ifu_arvalid = 1'b1;
    ifu_araddr  = addr;
    for (int k = 0; k < 50 && !ifu_arready; k++) tick();
    if (!ifu_arready) begin
      n_compared++;
      n_mismatched++;
      $display("[TB] FAIL ar_timeout: arready=%b for addr %h, expected 1", ifu_arready, addr);
    end else begin
      sb.push_back('{resp: resp, data: data});
      tick();
    end
    ifu_arvalid = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    for (int k = 0; k < 100 && sb.size() != 0; k++) tick();
    check_output(name, 64'(sb.size()), 64'd0);
  endtask

  always @(negedge clk) begin
    if (!syn_rst && ifu_rvalid === 1'b1 && ifu_rready === 1'b1) begin
      if (sb.size() == 0) begin
        n_compared++;
        n_mismatched++;
        $display("[TB] FAIL unexpected_rsp: got rresp=%b rdata=%h, expected no response", ifu_rresp, ifu_rdata);
      end else begin
        mon_e = sb.pop_front();
        check_output("rsp_rresp", 64'(ifu_rresp), 64'(mon_e.resp));
        check_output("rsp_rdata", ifu_rdata, mon_e.data);
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    syn_rst     = 1'b1;
    ifu_arvalid = 1'b0;
    ifu_araddr  = '0;
    ifu_rready  = 1'b1;
    mem_wen     = 1'b0;
    mem_waddr   = '0;
    mem_wdata   = '0;
    mem_wstrb   = '0;

    // Reset values, then arready once reset is released
    tick();
    tick();
    check_output("rst_rvalid", 64'(ifu_rvalid), 64'd0);
    check_output("rst_rresp", 64'(ifu_rresp), 64'd0);
    check_output("rst_rdata", ifu_rdata, 64'd0);
    syn_rst = 1'b0;
    tick();
    check_output("rst_arready", 64'(ifu_arready), 64'd1);

    backdoor_write(BASE + 64'h00, W0, 8'hFF);
    backdoor_write(BASE + 64'h08, W1, 8'hFF);
    backdoor_write(BASE + 64'h10, W2, 8'hFF);
    backdoor_write(BASE + 64'h18, W3, 8'hFF);
    backdoor_write(BASE + 64'h7FF8, WLAST, 8'hFF);

    // Latency: accept in T, rvalid low in T+1, high in T+2
    ifu_arvalid = 1'b1;
    ifu_araddr  = BASE;
    sb.push_back('{resp: 2'b00, data: W0});
    tick();
    ifu_arvalid = 1'b0;
    check_output("lat_rvalid_t1", 64'(ifu_rvalid), 64'd0);
    tick();
    check_output("lat_rvalid_t2", 64'(ifu_rvalid), 64'd1);
    wait_drain("lat_drain");

    // Fill to OSTD with rready low, then drain back-to-back
    ifu_rready = 1'b0;
    send_ar(BASE + 64'h00, 2'b00, W0);
    send_ar(BASE + 64'h08, 2'b00, W1);
    send_ar(BASE + 64'h10, 2'b00, W2);
    send_ar(BASE + 64'h18, 2'b00, W3);
    check_output("full_arready", 64'(ifu_arready), 64'd0);
    check_output("hold_rdata", ifu_rdata, W0);
    tick();
    tick();
    check_output("hold_rvalid", 64'(ifu_rvalid), 64'd1);
    check_output("hold_rdata2", ifu_rdata, W0);
    ifu_rready = 1'b1;
    for (int k = 0; k < 4; k++) tick();
    check_output("burst_drained", 64'(sb.size()), 64'd0);
    check_output("burst_rvalid", 64'(ifu_rvalid), 64'd0);
    check_output("burst_arready", 64'(ifu_arready), 64'd1);

    // Decode errors, edges of the window, dropped out-of-range backdoor writes
    backdoor_write(64'h0000_0000, 64'hBAD0_BAD0_BAD0_BAD0, 8'hFF);
    backdoor_write(BASE + 64'h8000, 64'hBAD1_BAD1_BAD1_BAD1, 8'hFF);
    send_ar(64'h0000_1000, 2'b11, 64'd0);
    send_ar(BASE + 64'h4, 2'b10, 64'd0);
    send_ar(64'h0000_1004, 2'b11, 64'd0);
    send_ar(BASE + 64'h8000, 2'b11, 64'd0);
    send_ar(BASE + 64'h7FF8, 2'b00, WLAST);
    send_ar(BASE + 64'h7FFF, 2'b10, 64'd0);
    send_ar(BASE, 2'b00, W0);
    wait_drain("decode_drain");

    // Backdoor write during the load cycle returns old data
    check_output("bd_arready", 64'(ifu_arready), 64'd1);
    ifu_arvalid = 1'b1;
    ifu_araddr  = BASE + 64'h08;
    sb.push_back('{resp: 2'b00, data: W1});
    tick();
    ifu_arvalid = 1'b0;
    backdoor_write(BASE + 64'h08, 64'hFFFF_FFFF_FFFF_FFFF, 8'h0F);
    send_ar(BASE + 64'h08, 2'b00, 64'h1111_1111_FFFF_FFFF);
    wait_drain("bd_drain");

    // Reset with outstanding reads drops them; memory survives
    ifu_rready = 1'b0;
    send_ar(BASE + 64'h00, 2'b00, W0);
    send_ar(BASE + 64'h10, 2'b00, W2);
    send_ar(BASE + 64'h18, 2'b00, W3);
    tick();
    tick();
    syn_rst = 1'b1;
    sb.delete();
    tick();
    syn_rst = 1'b0;
    check_output("mid_rst_rvalid", 64'(ifu_rvalid), 64'd0);
    check_output("mid_rst_arready", 64'(ifu_arready), 64'd1);
    ifu_rready = 1'b1;
    for (int k = 0; k < 10; k++) tick();
    check_output("mid_rst_quiet", 64'(ifu_rvalid), 64'd0);
    send_ar(BASE + 64'h10, 2'b00, W2);
    wait_drain("post_rst_drain");

    tick();
    tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
